// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: widths, bubble encoding, opcodes, ALUop codes
// and the decode-field helpers used by the pipeline registers.
package rv32_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [6:0] opcode_t;
    typedef logic [3:0] funct_t;

    localparam opcode_t OP_R      = 7'b0110011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_t;

    // ALUcontrol key: {instr[30], funct3}
    function automatic funct_t funct_of(input logic [31:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Flushable, stallable pipeline register carrying a PC, an instruction and a valid bit.
// Flush overrides enable and loads a bubble.
module if_id_reg #(
    parameter int          W   = 32,
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic [W-1:0]  pc_d,
    input  logic [31:0]   instr_d,
    input  logic          valid_d,
    output logic [W-1:0]  pc_q,
    output logic [31:0]   instr_q,
    output logic          valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (flush) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID latch and decode fields.
// Redirect beats stall, stall beats advance.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int               XLEN      = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [XLEN-1:0]  branchTarget,
    output logic [XLEN-1:0]  imemAddr,
    input  logic [31:0]      imemData,
    output logic [XLEN-1:0]  ifIdPc,
    output logic [31:0]      ifIdInstr,
    output logic             ifIdValid,
    output logic [6:0]       opcode,
    output logic [3:0]       funct,
    output logic [31:0]      fetchCount
);

    logic [XLEN-1:0] pc;
    logic            advance;

    assign advance  = ~stall & ~branchTaken;
    assign imemAddr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            fetchCount <= '0;
        end else if (branchTaken) begin
            pc <= {branchTarget[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc         <= pc + XLEN'(4);
            fetchCount <= fetchCount + 32'd1;
        end
    end

    if_id_reg #(
        .W   (XLEN),
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stall | branchTaken),
        .flush   (branchTaken),
        .pc_d    (pc),
        .instr_d (imemData),
        .valid_d (1'b1),
        .pc_q    (ifIdPc),
        .instr_q (ifIdInstr),
        .valid_q (ifIdValid)
    );

    // Bubbles decode as all-zero so Control falls into its default case.
    assign opcode = ifIdValid ? opcode_t'(ifIdInstr[6:0]) : '0;
    assign funct  = ifIdValid ? funct_of(ifIdInstr) : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main sequence plus
// hand-written async-reset sequence.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdInstr;
    logic        ifIdValid;
    logic [6:0]  opcode;
    logic [3:0]  funct;
    logic [31:0] fetchCount;

    int n_tests;
    int n_fail;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .ifIdPc       (ifIdPc),
        .ifIdInstr    (ifIdInstr),
        .ifIdValid    (ifIdValid),
        .opcode       (opcode),
        .funct        (funct),
        .fetchCount   (fetchCount)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] target;
        logic [31:0] data;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [6:0]  e_op;
        logic [3:0]  e_funct;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic e_valid, input logic [6:0] e_op,
                             input logic [3:0] e_funct, input logic [31:0] e_count);
        check({tag, ".imemAddr"},   imemAddr,            e_addr);
        check({tag, ".ifIdPc"},     ifIdPc,              e_pc);
        check({tag, ".ifIdInstr"},  ifIdInstr,           e_instr);
        check({tag, ".ifIdValid"},  {31'd0, ifIdValid},  {31'd0, e_valid});
        check({tag, ".opcode"},     {25'd0, opcode},     {25'd0, e_op});
        check({tag, ".funct"},      {28'd0, funct},      {28'd0, e_funct});
        check({tag, ".fetchCount"}, fetchCount,          e_count);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic [31:0] d);
        stall        = s;
        branchTaken  = b;
        branchTarget = t;
        imemData     = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic [31:0] d,
                       input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei,
                       input logic ev, input logic [6:0] eo, input logic [3:0] ef, input logic [31:0] ec);
        vec_t v;
        v.stall = s; v.br = b; v.target = t; v.data = d;
        v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_valid = ev;
        v.e_op = eo; v.e_funct = ef; v.e_count = ec;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0000_0033);

        //  st br target        data           addr          ifIdPc        instr         v  op        funct    count
        add(0, 0, 32'h0,        32'h0000_0033, 32'h4,        32'h0,        32'h0000_0033, 1, 7'h33, 4'b0000, 32'd1);
        add(0, 0, 32'h0,        32'h0000_0033, 32'h8,        32'h4,        32'h0000_0033, 1, 7'h33, 4'b0000, 32'd2);
        add(1, 0, 32'h0,        32'hDEAD_BEEF, 32'h8,        32'h4,        32'h0000_0033, 1, 7'h33, 4'b0000, 32'd2);
        add(1, 0, 32'h0,        32'h1234_5678, 32'h8,        32'h4,        32'h0000_0033, 1, 7'h33, 4'b0000, 32'd2);
        add(0, 0, 32'h0,        32'h4000_5033, 32'hC,        32'h8,        32'h4000_5033, 1, 7'h33, 4'b1101, 32'd3);
        add(0, 0, 32'h0,        32'h0000_2003, 32'h10,       32'hC,        32'h0000_2003, 1, 7'h03, 4'b0010, 32'd4);
        add(0, 0, 32'h0,        32'h0000_0013, 32'h14,       32'h10,       32'h0000_0013, 1, 7'h13, 4'b0000, 32'd5);
        add(0, 1, 32'h43,       32'hFFFF_FFFF, 32'h40,       32'h0,        32'h0000_0013, 0, 7'h00, 4'b0000, 32'd5);
        add(0, 0, 32'h0,        32'h0000_0063, 32'h44,       32'h40,       32'h0000_0063, 1, 7'h63, 4'b0000, 32'd6);
        add(1, 1, 32'h100,      32'h0000_0033, 32'h100,      32'h0,        32'h0000_0013, 0, 7'h00, 4'b0000, 32'd6);
        add(0, 1, 32'h200,      32'h0000_0033, 32'h200,      32'h0,        32'h0000_0013, 0, 7'h00, 4'b0000, 32'd6);
        add(0, 1, 32'hFFFF_FFFE, 32'h0000_0033, 32'hFFFF_FFFC, 32'h0,     32'h0000_0013, 0, 7'h00, 4'b0000, 32'd6);
        add(0, 0, 32'h0,        32'h0000_0033, 32'h0,        32'hFFFF_FFFC, 32'h0000_0033, 1, 7'h33, 4'b0000, 32'd7);
        add(0, 0, 32'h0,        32'h0000_0013, 32'h4,        32'h0,        32'h0000_0013, 1, 7'h13, 4'b0000, 32'd8);

        // reset values, held across an edge while rst_n is low
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 7'h00, 4'b0000, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].target, vecs[i].data);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_op, vecs[i].e_funct, vecs[i].e_count);
        end

        // async reset mid-stall, between edges
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0033);
        step();
        check_all("stall_pre_rst", 32'h4, 32'h0, 32'h0000_0013, 1'b1, 7'h13, 4'b0000, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 7'h00, 4'b0000, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0000_0033);
        step();
        check_all("rst_held", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 7'h00, 4'b0000, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check_all("restart", 32'h4, 32'h0, 32'h0000_0033, 1'b1, 7'h33, 4'b0000, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the RV32I pipelined datapath.
- Holds the PC and drives the instruction-memory read address.
- Latches each fetched instruction with its PC and presents decode fields to the downstream Control and ALUcontrol blocks:
  - opcode goes to Control.
  - {instr[30], instr[14:12]} goes to ALUcontrol.
- Honours load-use stalls from the hazard unit and flushes on taken branches resolved downstream.

Parameters:
- XLEN, 32: datapath and PC width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- NOP_INSTR, 32'h0000_0013: bubble instruction (addi x0,x0,0) loaded on flush and reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID contents (load-use hazard).
- branchTaken  in  1  redirect fetch and squash IF/ID this cycle.
- branchTarget  in  XLEN  redirect address.
- imemAddr  out  XLEN  instruction-memory address (combinational read).
- imemData  in  32  instruction word at imemAddr, valid the same cycle.
- ifIdPc  out  XLEN  PC of the instruction in IF/ID.
- ifIdInstr  out  32  instruction in IF/ID.
- ifIdValid  out  1  IF/ID holds a real instruction (0 = bubble).
- opcode  out  7  ifIdInstr[6:0] when valid, else 7'b0000000.
- funct  out  4  {ifIdInstr[30], ifIdInstr[14:12]} when valid, else 4'b0000.
- fetchCount  out  32  number of valid instructions latched into IF/ID since reset.

Behaviour:
- Reset (async, rst_n=0), all values held while rst_n is low:
  - pc=RESET_PC
  - ifIdPc=0
  - ifIdInstr=NOP_INSTR
  - ifIdValid=0
  - fetchCount=0
- Reset release is synchronous to the next clk edge. The first fetch is from RESET_PC.
- imemAddr = pc, combinational, with no added latency. Fetch-to-IF/ID latency is 1 cycle.
- Per rising edge, priority is branchTaken > stall > advance.
- branchTaken=1, regardless of stall:
  - pc <= {branchTarget[XLEN-1:2], 2'b00}; low bits are forced to zero.
  - IF/ID <= bubble: ifIdPc=0, ifIdInstr=NOP_INSTR, ifIdValid=0.
  - fetchCount is unchanged.
- stall=1, branchTaken=0: pc, ifIdPc, ifIdInstr, ifIdValid and fetchCount all hold.
- Advance (neither asserted):
  - pc <= pc+4, computed modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - ifIdPc <= pc, ifIdInstr <= imemData, ifIdValid <= 1.
  - fetchCount <= fetchCount+1, wrapping at 2^32.
- opcode and funct are combinational from the IF/ID register. They are forced to zero when ifIdValid=0, so Control decodes its default case (all control outputs 0) and ALUcontrol sees 4'b0000.
- branchTaken held for multiple cycles: each cycle redirects to the current branchTarget and keeps inserting bubbles.
- imemData is sampled only on an advance edge. Its value during a stall or flush is ignored.
- No X propagation: every register has a reset value, and the opcode/funct outputs are defined in every state.

Decomposition:
- Shared package (rv32_pkg):
  - XLEN
  - NOP_INSTR
  - opcode constants: OP_R=7'b0110011, OP_LOAD=7'b0000011, OP_IMM=7'b0010011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011
  - ALUop encodings: 2'b00 add, 2'b01 branch, 2'b10 R-type
- Sub-module if_id_reg holds ifIdPc, ifIdInstr and ifIdValid. It has inputs en (= ~stall | branchTaken) and flush (= branchTaken), with flush taking priority. It is reused later for ID/EX-style registers.
- PC register, adder, field extraction and counter stay in fetch_stage.

Test Plan:
- Reset then release, imemData=32'h0000_0033 constant, 3 edges:
  - edge 1: ifIdPc=0, ifIdValid=1, opcode=7'b0110011, fetchCount=1.
  - after edge 3: imemAddr=12, ifIdPc=8, fetchCount=3.
- Advance to pc=8, assert stall for 2 cycles with imemData changing: imemAddr stays 8, ifIdInstr/ifIdPc/fetchCount unchanged. On release, the next edge latches pc=8 and pc becomes 12.
- branchTaken=1 with branchTarget=32'h0000_0043, at pc=20:
  - next edge: imemAddr=32'h40, ifIdValid=0, opcode=0, funct=0, fetchCount unchanged.
  - following edge: ifIdPc=32'h40.
- stall=1 and branchTaken=1 with branchTarget=32'h100 in the same cycle: redirect wins, so pc=32'h100 and IF/ID is a bubble.
- Redirect to 32'hFFFF_FFFC, then advance twice: ifIdPc=32'hFFFF_FFFC, then imemAddr=0. Also preload fetchCount=32'hFFFF_FFFF through 2^32 fetches (or force), and check it wraps to 0.
- Assert rst_n=0 mid-stall, asynchronously between edges: outputs go to reset values immediately without a clock edge, and fetch restarts at RESET_PC after release.
